temp_bcd_conv: RTL

- Converts a raw DS18B20-format temperature word (16-bit two's complement, 0.0625 °C/LSB) into a sign bit plus six packed BCD digits in XX.XXXX °C form.
- Sits between the 1-wire temperature reader and the LCD12864 display driver.
- The display driver consumes dout_sign and dout_bcd[23:4] as tens, ones, tenths, hundredths and thousandths.
- Conversion is sequential: one scale/clamp cycle, then 20 double-dabble shift-add-3 cycles.

---
 rtl/temp_bcd_conv_if.sv | 23 ++
 rtl/temp_bcd_conv.sv | 131 +++++++++++++
 2 files changed

// File: rtl/temp_bcd_conv_if.sv
// Handshake and result bundle between the temperature reader, the BCD converter and the LCD driver.
// The master side drives the raw word; the slave side (converter) returns the BCD result.
interface temp_bcd_conv_if #(
    parameter int unsigned RAW_W = 16
);
    logic [RAW_W-1:0] temp_raw;
    logic             temp_vld;
    logic             busy;
    logic             dout_sign;
    logic [23:0]      dout_bcd;
    logic             dout_ovf;
    logic             dout_vld;

    modport master (
        output temp_raw, temp_vld,
        input  busy, dout_sign, dout_bcd, dout_ovf, dout_vld
    );

    modport slave (
        input  temp_raw, temp_vld,
        output busy, dout_sign, dout_bcd, dout_ovf, dout_vld
    );
endinterface

// File: rtl/temp_bcd_conv.sv
// Converts a DS18B20 temperature word into sign + six BCD digits (XX.XXXX degC).
// One scale/clamp cycle, then a 20-step double-dabble; results are held until the next conversion.
module temp_bcd_conv #(
    parameter int unsigned RAW_W   = 16,
    parameter int unsigned SCALE   = 625,
    parameter int unsigned MAX_VAL = 999999,
    parameter int unsigned BIN_W   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    temp_bcd_conv_if.slave   bus_io
);
    localparam int unsigned ScaledW = RAW_W + 10;
    localparam int unsigned CntW    = $clog2(BIN_W);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [RAW_W-1:0]   raw_q, raw_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [23:0]        bcd_q, bcd_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               dout_sign_q, dout_sign_d;
    logic [23:0]        dout_bcd_q, dout_bcd_d;
    logic               dout_ovf_q, dout_ovf_d;
    logic               dout_vld_q, dout_vld_d;

    logic [RAW_W-1:0]   mag;
    logic [ScaledW-1:0] scaled;
    logic [23:0]        bcd_adj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            raw_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            dout_sign_q <= 1'b0;
            dout_bcd_q  <= '0;
            dout_ovf_q  <= 1'b0;
            dout_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            raw_q       <= raw_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            dout_sign_q <= dout_sign_d;
            dout_bcd_q  <= dout_bcd_d;
            dout_ovf_q  <= dout_ovf_d;
            dout_vld_q  <= dout_vld_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        raw_d       = raw_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        ovf_d       = ovf_q;
        busy_d      = busy_q;
        dout_sign_d = dout_sign_q;
        dout_bcd_d  = dout_bcd_q;
        dout_ovf_d  = dout_ovf_q;
        dout_vld_d  = 1'b0;
        mag         = '0;
        scaled      = '0;
        bcd_adj     = bcd_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.temp_vld) begin
                    raw_d   = bus_io.temp_raw;
                    busy_d  = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                sign_d = raw_q[RAW_W-1];
                // Negation stays 16-bit unsigned so 0x8000 yields 32768.
                mag    = raw_q[RAW_W-1] ? -raw_q : raw_q;
                scaled = ScaledW'(mag) * ScaledW'(SCALE);
                if (scaled > ScaledW'(MAX_VAL)) begin
                    bin_d = BIN_W'(MAX_VAL);
                    ovf_d = 1'b1;
                end else begin
                    bin_d = scaled[BIN_W-1:0];
                    ovf_d = 1'b0;
                end
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                for (int i = 0; i < 6; i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                end
                bcd_d = {bcd_adj[22:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(BIN_W - 1)) state_d = StDone;
            end
            StDone: begin
                dout_sign_d = sign_q;
                dout_bcd_d  = bcd_q;
                dout_ovf_d  = ovf_q;
                dout_vld_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    assign bus_io.busy      = busy_q;
    assign bus_io.dout_sign = dout_sign_q;
    assign bus_io.dout_bcd  = dout_bcd_q;
    assign bus_io.dout_ovf  = dout_ovf_q;
    assign bus_io.dout_vld  = dout_vld_q;
endmodule
